// File: rtl/semaforo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_ctrl
// Description : Three-road traffic-light controller; round-robin green grant
//               with timed green/yellow/all-red sequence driven by tick.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_ctrl #(
    parameter int T_GREEN_MIN = 8,
    parameter int T_GREEN_MAX = 32,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] sensor,
    output logic       vm_a,
    output logic       am_a,
    output logic       vd_a,
    output logic       vm_b,
    output logic       am_b,
    output logic       vd_b,
    output logic       vm_c,
    output logic       am_c,
    output logic       vd_c,
    output logic [1:0] active,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

    localparam logic [1:0]       c_road_a    = 2'd0;
    localparam logic [1:0]       c_road_b    = 2'd1;
    localparam logic [1:0]       c_road_c    = 2'd2;
    localparam logic [CNT_W-1:0] c_green_min = CNT_W'(T_GREEN_MIN);
    localparam logic [CNT_W-1:0] c_green_max = CNT_W'(T_GREEN_MAX);
    localparam logic [CNT_W-1:0] c_yellow    = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] c_allred    = CNT_W'(T_ALLRED);

    phase_t           r_phase;
    logic [1:0]       r_cur;
    logic [CNT_W-1:0] r_cnt;

    phase_t           w_phase_nxt;
    logic [1:0]       w_cur_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_own_req;
    logic             w_other_req;
    logic             w_want_change;
    logic [1:0]       w_rr_road;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_GREEN;
            r_cur   <= c_road_a;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Sensor bit order is A=bit2, B=bit1, C=bit0.
    always_comb begin
        w_own_req   = 1'b0;
        w_other_req = |sensor;
        w_rr_road   = c_road_a;
        case (r_cur)
            c_road_a: begin
                w_own_req   = sensor[2];
                w_other_req = sensor[1] | sensor[0];
                if      (sensor[1]) w_rr_road = c_road_b;
                else if (sensor[0]) w_rr_road = c_road_c;
                else                w_rr_road = c_road_a;
            end
            c_road_b: begin
                w_own_req   = sensor[1];
                w_other_req = sensor[2] | sensor[0];
                if      (sensor[0]) w_rr_road = c_road_c;
                else if (sensor[2]) w_rr_road = c_road_a;
                else if (sensor[1]) w_rr_road = c_road_b;
                else                w_rr_road = c_road_a;
            end
            c_road_c: begin
                w_own_req   = sensor[0];
                w_other_req = sensor[2] | sensor[1];
                if      (sensor[2]) w_rr_road = c_road_a;
                else if (sensor[1]) w_rr_road = c_road_b;
                else if (sensor[0]) w_rr_road = c_road_c;
                else                w_rr_road = c_road_a;
            end
            default: begin
                w_own_req   = 1'b0;
                w_other_req = |sensor;
                w_rr_road   = c_road_a;
            end
        endcase
        w_want_change = w_other_req | ((r_cur != c_road_a) && (sensor == 3'b000));
    end

    always_comb begin
        w_cnt_inc   = (r_cnt >= c_green_max) ? c_green_max : r_cnt + 1'b1;
        w_phase_nxt = r_phase;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        if (tick) begin
            w_cnt_nxt = w_cnt_inc;
            case (r_phase)
                PH_GREEN: begin
                    if ((w_cnt_inc >= c_green_min) && w_want_change &&
                        (!w_own_req || (w_cnt_inc >= c_green_max))) begin
                        w_phase_nxt = PH_YELLOW;
                        w_cnt_nxt   = '0;
                    end
                end
                PH_YELLOW: begin
                    if (w_cnt_inc == c_yellow) begin
                        w_phase_nxt = PH_ALLRED;
                        w_cnt_nxt   = '0;
                    end
                end
                PH_ALLRED: begin
                    if (w_cnt_inc == c_allred) begin
                        w_phase_nxt = PH_GREEN;
                        w_cur_nxt   = w_rr_road;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_phase_nxt = PH_GREEN;
                    w_cur_nxt   = c_road_a;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        vm_a = 1'b1; am_a = 1'b0; vd_a = 1'b0;
        vm_b = 1'b1; am_b = 1'b0; vd_b = 1'b0;
        vm_c = 1'b1; am_c = 1'b0; vd_c = 1'b0;
        if (r_phase == PH_GREEN) begin
            case (r_cur)
                c_road_a: begin vm_a = 1'b0; vd_a = 1'b1; end
                c_road_b: begin vm_b = 1'b0; vd_b = 1'b1; end
                c_road_c: begin vm_c = 1'b0; vd_c = 1'b1; end
                default:  ;
            endcase
        end else if (r_phase == PH_YELLOW) begin
            case (r_cur)
                c_road_a: begin vm_a = 1'b0; am_a = 1'b1; end
                c_road_b: begin vm_b = 1'b0; am_b = 1'b1; end
                c_road_c: begin vm_c = 1'b0; am_c = 1'b1; end
                default:  ;
            endcase
        end
    end

    assign active = r_cur;
    assign phase  = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_ctrl
// Description : Self-checking bench for semaforo_ctrl; directed timing checks
//               plus randomized traffic against a behavioural road model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_ctrl;

    localparam int T_GREEN_MIN = 8;
    localparam int T_GREEN_MAX = 32;
    localparam int T_YELLOW    = 3;
    localparam int T_ALLRED    = 1;
    localparam int CNT_W       = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic       vm_a, am_a, vd_a, vm_b, am_b, vd_b, vm_c, am_c, vd_c;
    logic [1:0] active, phase;
    logic [8:0] lamps;

    int n_cmp = 0;
    int n_err = 0;

    // Model: road owning the phase, phase (0 green,1 yellow,2 all-red),
    // and unbounded ticks elapsed inside the current phase.
    int m_road = 0, m_ph = 0, m_el = 0;
    int n_road, n_ph, n_el;

    semaforo_ctrl #(
        .T_GREEN_MIN(T_GREEN_MIN), .T_GREEN_MAX(T_GREEN_MAX),
        .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .sensor(sensor),
        .vm_a(vm_a), .am_a(am_a), .vd_a(vd_a),
        .vm_b(vm_b), .am_b(am_b), .vd_b(vd_b),
        .vm_c(vm_c), .am_c(am_c), .vd_c(vd_c),
        .active(active), .phase(phase)
    );

    assign lamps = {vm_a, am_a, vd_a, vm_b, am_b, vd_b, vm_c, am_c, vd_c};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_lamps();
        logic [8:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            if (r == m_road && m_ph == 0)      v[8-3*r -: 3] = 3'b001;
            else if (r == m_road && m_ph == 1) v[8-3*r -: 3] = 3'b010;
            else                               v[8-3*r -: 3] = 3'b100;
        end
        return v;
    endfunction

    function automatic bit road_wants(input logic [2:0] s, input int r);
        return s[2-r];
    endfunction

    task automatic model_step(input logic r, input logic t, input logic [2:0] s);
        int  el;
        bit  own, other, rest;
        n_road = m_road; n_ph = m_ph; n_el = m_el;
        if (r) begin
            n_road = 0; n_ph = 0; n_el = 0;
        end else if (t) begin
            el    = m_el + 1;
            n_el  = el;
            own   = road_wants(s, m_road);
            other = 0;
            for (int k = 0; k < 3; k++)
                if (k != m_road && road_wants(s, k)) other = 1;
            rest  = (m_road != 0) && (s == 3'b000);
            if (m_ph == 0) begin
                if (el >= T_GREEN_MIN && (other || rest) && (!own || el >= T_GREEN_MAX)) begin
                    n_ph = 1; n_el = 0;
                end
            end else if (m_ph == 1) begin
                if (el == T_YELLOW) begin n_ph = 2; n_el = 0; end
            end else begin
                if (el == T_ALLRED) begin
                    n_ph = 0; n_el = 0; n_road = 0;
                    for (int k = 3; k >= 1; k--)
                        if (road_wants(s, (m_road + k) % 3)) n_road = (m_road + k) % 3;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic [2:0] s);
        reset = r; tick = t; sensor = s;
        model_step(r, t, s);
        @(posedge clk);
        #1;
        m_road = n_road; m_ph = n_ph; m_el = n_el;
        chk("lamps", 16'(lamps), 16'(model_lamps()));
        chk("active", 16'(active), 16'(m_road));
        chk("phase", 16'(phase), 16'(m_ph));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 3'b000);
    endtask

    initial begin
        #1;
        do_reset();
        do_reset();
        chk("reset_lamps", 16'(lamps), 16'(9'b001_100_100));
        chk("reset_active", 16'(active), 16'd0);

        // Rest road with no demand.
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 3'b000);
        chk("rest_lamps", 16'(lamps), 16'(9'b001_100_100));
        chk("rest_phase", 16'(phase), 16'd0);

        // Minimum green then B.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b1, 3'b010);
            if (i == 7)  chk("mingreen_a7", 16'(vd_a), 16'd1);
            if (i == 8)  chk("yellow_a8", 16'(am_a), 16'd1);
            if (i == 10) chk("yellow_a10", 16'(am_a), 16'd1);
            if (i == 11) chk("allred11", 16'(lamps), 16'(9'b100_100_100));
            if (i == 12) chk("green_b12", 16'(lamps), 16'(9'b100_001_100));
        end
        chk("hold_b", 16'(vd_b), 16'd1);

        // Round-robin max-out.
        do_reset();
        for (int i = 1; i <= 110; i++) begin
            cyc(1'b0, 1'b1, 3'b111);
            if (i == 31)  chk("max_a31", 16'(phase), 16'd0);
            if (i == 32)  chk("max_a32", 16'(phase), 16'd1);
            if (i == 36)  chk("max_b36", 16'({active, phase}), 16'({2'd1, 2'd0}));
            if (i == 72)  chk("max_c72", 16'({active, phase}), 16'({2'd2, 2'd0}));
            if (i == 108) chk("max_a108", 16'({active, phase}), 16'({2'd0, 2'd0}));
        end

        // Gap-out to C, then return to rest.
        do_reset();
        for (int i = 1; i <= 11; i++) cyc(1'b0, 1'b1, 3'b101);
        cyc(1'b0, 1'b1, 3'b001);
        chk("gapout12", 16'(phase), 16'd1);
        for (int i = 13; i <= 16; i++) cyc(1'b0, 1'b1, 3'b001);
        chk("gapout_c", 16'(lamps), 16'(9'b100_100_001));
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3'b001);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 3'b000);
        chk("rest_return", 16'({active, phase, vd_a}), 16'({2'd0, 2'd0, 1'b1}));

        // Reset during yellow.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 3'b010);
        chk("pre_reset_yellow", 16'(am_a), 16'd1);
        do_reset();
        chk("reset_midyellow", 16'(lamps), 16'(9'b001_100_100));

        // Tick gating.
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 3'b010);
        chk("tick_gate", 16'({active, phase, vd_a}), 16'({2'd0, 2'd0, 1'b1}));

        // Randomized traffic.
        begin
            logic [2:0] s;
            s = 3'b000;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 15) == 0) s = 3'($urandom_range(0, 7));
                else if ($urandom_range(0, 63) == 0) s[$urandom_range(0, 2)] ^= 1'b1;
                cyc(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 3) != 0), s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/semaforo_ctrl.md
Name: semaforo_ctrl

Overview:
- Sequential controller for a three-road intersection (roads A, B, C); each road has a red/yellow/green head.
- Grants green to exactly one road at a time. Each green runs a timed green -> yellow -> all-red sequence.
- Next road is chosen round-robin among roads with an active car sensor. Road A is the rest road when there is no demand.
- Sits between the sensor conditioning logic and the lamp drivers. All timing is counted in `tick` pulses from an external prescaler.

Parameters:
- T_GREEN_MIN, 8, minimum green duration in ticks
- T_GREEN_MAX, 32, green duration after which the phase ends even if its own sensor is still active and another road waits
- T_YELLOW, 3, yellow duration in ticks
- T_ALLRED, 1, all-red clearance duration in ticks
- CNT_W, 6, phase counter width
- Legal range: 1 <= T_GREEN_MIN <= T_GREEN_MAX < 2^CNT_W; T_YELLOW >= 1; T_ALLRED >= 1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  single-cycle timing enable; the counter advances only when tick=1
- sensor  in  3  car presence; bit2=A, bit1=B, bit0=C; synchronous to clk (synchronisers are upstream)
- vm_a, am_a, vd_a  out  1 each  road A red / yellow / green
- vm_b, am_b, vd_b  out  1 each  road B red / yellow / green
- vm_c, am_c, vd_c  out  1 each  road C red / yellow / green
- active  out  2  road currently owning the phase: 0=A, 1=B, 2=C (3 is never driven)
- phase  out  2  0=GREEN, 1=YELLOW, 2=ALLRED

Behaviour:
- Registered state: phase, active road `cur`, and counter `cnt` (CNT_W bits).
- Outputs are a combinational decode of the registers and change the cycle after the state edge.
- Lamp decode:
  - Road cur shows green in GREEN and yellow in YELLOW; every other road is red.
  - In ALLRED all three roads are red.
  - Exactly one lamp per road is lit in every cycle.
- Reset (synchronous, overrides everything, including mid-phase):
  - phase=GREEN, cur=A, cnt=0.
  - Outputs: vd_a=1, vm_b=1, vm_c=1, all other lamps 0.
- tick=0: state and cnt hold, and no transition occurs. All decisions below are evaluated only in cycles with tick=1.
- Counter rule on a tick: cnt_next = cnt+1, saturating at T_GREEN_MAX. Every phase change loads cnt=0.
- Demand signals, evaluated on the tick cycle using the current sensor value:
  - other_req = any sensor bit set for a road other than cur.
  - rest_req = (cur != A) and (sensor == 0).
  - want_change = other_req or rest_req.
- GREEN -> YELLOW on a tick where all of the following hold:
  - cnt_next >= T_GREEN_MIN, and
  - want_change, and
  - either sensor[cur] == 0 (gap-out) or cnt_next >= T_GREEN_MAX (max-out).
- GREEN otherwise holds. With no competing demand, green is held indefinitely; cnt saturates and never wraps.
- YELLOW -> ALLRED on the tick where cnt_next == T_YELLOW.
- ALLRED -> GREEN on the tick where cnt_next == T_ALLRED. The new cur is chosen in that same cycle:
  - Scan cur+1, cur+2, cur (mod 3); the first road with its sensor set wins.
  - If no sensor is set, the new cur is A.
  - Re-granting the same road is legal.
- Sensor changes during YELLOW or ALLRED never abort the sequence. Once YELLOW is entered, the sequence always completes.
- Fixed latency:
  - Leaving GREEN costs exactly T_YELLOW + T_ALLRED ticks before the next green.
  - The minimum green time is T_GREEN_MIN ticks.
- Two roads are never green or yellow at the same time, in any reachable state.

Test Plan:
- Rest road: reset, sensor=000, tick every cycle for 100 cycles -> vd_a=1, vm_b=vm_c=1, phase=0, active=0 throughout.
- Minimum green and sequence: after reset, set sensor=010 and tick every cycle:
  - A green through tick 7.
  - Yellow A on ticks 8-10 (am_a=1).
  - All-red after tick 11.
  - B green after tick 12, and B stays green while sensor=010 is held.
- Round-robin max-out: sensor=111 held -> greens last 32 ticks each, in order A, B, C, A, with 3 yellow ticks and 1 all-red tick between them.
- Gap-out: A green, sensor=101, clear bit2 at tick 12 -> YELLOW entered on tick 12, then C green.
- Return to rest: C green, drop sensor to 000 after tick 8 -> yellow C, all-red, then A green with active=0.
- Reset and tick gating:
  - Assert reset for one cycle during YELLOW -> next cycle shows the reset state (vd_a=1).
  - Hold tick=0 for 50 cycles in GREEN with sensor=010 -> no transition.
